// File: rtl/cell_pos_pkg.sv
// -----------------------------------------------------------------------------
// cell_pos_pkg
// Shared types and constants for the double-buffered cell position store.
//   state_e     : swap controller states (IDLE, DRAIN, SWAP)
//   rd_kind_e   : how an accepted read is resolved when its data returns
//   RD_LATENCY  : cycles from an accepted rd_en to rd_valid
// -----------------------------------------------------------------------------
package cell_pos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  // Decided at accept time against the active count of that moment, so a
  // read stays consistent with the bank it was issued to.
  typedef enum logic [1:0] {
    RD_COUNT = 2'd0,
    RD_RAM   = 2'd1,
    RD_ZERO  = 2'd2
  } rd_kind_e;

  localparam int RD_LATENCY = 2;

endpackage

// File: rtl/cell_pos_bank.sv
// -----------------------------------------------------------------------------
// cell_pos_bank
// One particle bank: single-port RAM of DEPTH x DATA_WIDTH with a registered
// address and a registered output, giving a 2-cycle read. No reset on the
// storage so it maps onto a block RAM.
//   clk_i    : clock
//   we_i     : write enable (write to addr_i this edge)
//   addr_i   : read/write address
//   wdata_i  : write data
//   rdata_o  : registered read data for the address presented two edges ago
// -----------------------------------------------------------------------------
module cell_pos_bank #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 220,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    addr_q  <= addr_i;
    rdata_q <= mem_q[addr_q];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cell_pos_pingpong.sv
// -----------------------------------------------------------------------------
// cell_pos_pingpong
// Double-buffered per-cell particle position store. Reads are served from the
// active bank, appends go to the shadow bank, and a swap handshake exchanges
// the two banks between timesteps.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   rd_en_i, rd_addr_i     : read request (addr 0 = count, 1..count = records)
//   rd_ready_o             : read accepted this cycle when high (IDLE only)
//   rd_valid_o, rd_data_o  : read result, RD_LATENCY cycles after accept
//   wr_valid_i, wr_data_i  : append request to the shadow bank
//   wr_ready_o             : append accepted when high (IDLE and not full)
//   swap_req_i             : pulse requesting a bank exchange
//   swap_done_o            : pulse in the cycle the exchange takes effect
//   active_count_o         : particle count of the active bank
//   overflow_o             : sticky, an append arrived while the shadow was full
// -----------------------------------------------------------------------------
module cell_pos_pingpong
  import cell_pos_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  input  logic                  swap_req_i,
  output logic                  swap_done_o,
  output logic [ADDR_WIDTH-1:0] active_count_o,
  output logic                  overflow_o
);

  // Address 0 is reserved for the count, so one word is lost per bank.
  localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef struct packed {
    logic                  valid;
    rd_kind_e              kind;
    logic                  bank;
    logic [ADDR_WIDTH-1:0] count;
  } rd_tag_t;

  state_e                state_q, state_d;
  logic                  bank_sel_q;
  logic [ADDR_WIDTH-1:0] active_count_q;
  logic [ADDR_WIDTH-1:0] shadow_count_q;
  logic                  overflow_q;
  rd_tag_t               tag_q [RD_LATENCY];
  rd_tag_t               tag_d;
  logic [DATA_WIDTH-1:0] rd_hold_q;
  logic [DATA_WIDTH-1:0] rd_result;
  logic [DATA_WIDTH-1:0] bank_rdata [2];

  logic                  is_idle;
  logic                  shadow_full;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  pipe_busy;
  rd_kind_e              rd_kind;

  assign is_idle     = (state_q == ST_IDLE);
  assign shadow_full = (shadow_count_q == FULL_COUNT);
  assign rd_ready_o  = is_idle;
  assign wr_ready_o  = is_idle && !shadow_full;
  assign rd_accept   = rd_en_i && is_idle;
  assign wr_accept   = wr_valid_i && wr_ready_o;

  // ---------------------------------------------------------------------------
  // Read classification and tag pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_kind = RD_ZERO;
    if (rd_addr_i == '0) begin
      rd_kind = RD_COUNT;
    end else if (rd_addr_i <= active_count_q) begin
      rd_kind = RD_RAM;
    end
  end

  always_comb begin
    tag_d       = '0;
    tag_d.valid = rd_accept;
    tag_d.kind  = rd_kind;
    tag_d.bank  = bank_sel_q;
    tag_d.count = active_count_q;
  end

  // A read is still in flight after this cycle if any stage but the last
  // holds one; the last stage is delivering its data right now.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      pipe_busy = pipe_busy | tag_q[i].valid;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      rd_hold_q <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (tag_q[RD_LATENCY-1].valid) begin
        rd_hold_q <= rd_result;
      end
    end
  end

  always_comb begin
    rd_result = '0;
    case (tag_q[RD_LATENCY-1].kind)
      RD_COUNT: rd_result = DATA_WIDTH'(tag_q[RD_LATENCY-1].count);
      RD_RAM:   rd_result = bank_rdata[tag_q[RD_LATENCY-1].bank];
      default:  rd_result = '0;
    endcase
  end

  assign rd_valid_o = tag_q[RD_LATENCY-1].valid;
  assign rd_data_o  = rd_valid_o ? rd_result : rd_hold_q;

  // ---------------------------------------------------------------------------
  // Swap controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    swap_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (swap_req_i) begin
          state_d = (pipe_busy || rd_accept) ? ST_DRAIN : ST_SWAP;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        swap_done_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      bank_sel_q     <= 1'b0;
      active_count_q <= '0;
      shadow_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // No append can be accepted during SWAP, so the two branches never race.
      if (state_q == ST_SWAP) begin
        bank_sel_q     <= ~bank_sel_q;
        active_count_q <= shadow_count_q;
        shadow_count_q <= '0;
      end else if (wr_accept) begin
        shadow_count_q <= shadow_count_q + ADDR_WIDTH'(1);
      end
      // Only a full bank counts as overflow; a write stalled by DRAIN/SWAP is
      // held by the source and retried.
      if (wr_valid_i && is_idle && shadow_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign active_count_o = active_count_q;
  assign overflow_o     = overflow_q;

  // ---------------------------------------------------------------------------
  // Banks: the active one sees the read address, the shadow one the append
  // address. Record i lives at address i, hence shadow_count + 1.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic                  is_active;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;

    assign is_active = (bank_sel_q == 1'(gi));
    assign addr      = is_active ? rd_addr_i : (shadow_count_q + ADDR_WIDTH'(1));
    assign we        = !is_active && wr_accept;

    cell_pos_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (PARTICLE_NUM),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wr_data_i),
      .rdata_o (bank_rdata[gi])
    );
  end

endmodule
